// File: rtl/serial_add_sched.sv
// Bit-serial adder shared by two requesters through a round-robin arbiter.
// One full adder is used for one bit per RUN cycle, LSB first.
module serial_add_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q, last_q;
  logic             gnt0_q, gnt1_q, busy_q, done_q, owner_q;
  logic             fa_s, fa_c, pick1;

  always_comb begin
    fa_s  = opa_q[0] ^ opb_q[0] ^ c_q;
    fa_c  = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
    res_d = res_q >> 1;
    res_d[WIDTH-1] = fa_s;
    // last_q resets to 1 so requester 0 wins the first contested grant
    pick1 = req1 & (~req0 | ~last_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            owner_q <= pick1;
            last_q  <= pick1;
            opa_q   <= pick1 ? a1 : a0;
            opb_q   <= pick1 ? b1 : b0;
            c_q     <= pick1 ? cin1 : cin0;
          end
        end
        RUN: begin
          res_q <= res_d;
          c_q   <= fa_c;
          opa_q <= opa_q >> 1;
          opb_q <= opb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign sum   = res_q;
  assign carry = c_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed + randomized bench for serial_add_sched (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0, req1, cin0, cin1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, done, owner, carry;
  logic [7:0] sum;

  logic       rq0_w1, rq1_w1, x0_w1, y0_w1, c0_w1, x1_w1, y1_w1, c1_w1;
  logic       gnt0_w1, gnt1_w1, busy_w1, done_w1, owner_w1, carry_w1;
  logic [0:0] sum_w1;

  int   checks = 0;
  int   errors = 0;
  logic last   = 1'b1;

  serial_add_sched #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .sum(sum), .carry(carry)
  );

  serial_add_sched #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0(rq0_w1), .a0(x0_w1), .b0(y0_w1), .cin0(c0_w1),
    .req1(rq1_w1), .a1(x1_w1), .b1(y1_w1), .cin1(c1_w1),
    .gnt0(gnt0_w1), .gnt1(gnt1_w1), .busy(busy_w1), .done(done_w1),
    .owner(owner_w1), .sum(sum_w1), .carry(carry_w1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset8();
    chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_owner", owner, 0); chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
  endtask

  // Serves whichever requester the round-robin rule picks from the current reqs.
  task automatic serve8(input int raise1_at, output int waited);
    logic       w;
    logic [8:0] full;
    w = (req0 && req1) ? ~last : req1;
    full = w ? (9'(a1) + 9'(b1) + 9'(cin1)) : (9'(a0) + 9'(b0) + 9'(cin0));
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(gnt0 || gnt1) && waited < 40);
    chk("gnt0", gnt0, !w);
    chk("gnt1", gnt1, w);
    chk("busy_gnt", busy, 1);
    chk("owner_gnt", owner, w);
    last = w;
    if (w) begin
      req1 = 0; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
    end else begin
      req0 = 0; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    end
    for (int i = 1; i <= 8; i++) begin
      if (i == raise1_at) begin
        req1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      end
      @(negedge clk);
      chk("gnt0_run", gnt0, 0);
      chk("gnt1_run", gnt1, 0);
      chk("busy_run", busy, 1);
      chk("done_timing", done, (i == 8));
    end
    chk("sum", sum, full[7:0]);
    chk("carry", carry, full[8]);
    chk("owner", owner, w);
  endtask

  initial begin
    int         w;
    int         t;
    int         tot;
    logic       held;
    logic [2:0] cv;

    rst_n = 0;
    req0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    req1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
    rq0_w1 = 0; rq1_w1 = 0;
    x0_w1 = 0; y0_w1 = 0; c0_w1 = 0; x1_w1 = 0; y1_w1 = 0; c1_w1 = 0;
    repeat (3) @(negedge clk);
    chk_reset8();
    chk("rst_w1_busy", busy_w1, 0);
    chk("rst_w1_sum", sum_w1, 0);

    // both held from reset release: 0 first, then 1 two cycles after done
    rst_n = 1;
    serve8(0, w); chk("first_wait", w, 1);
    serve8(0, w); chk("b2b_wait", w, 2);

    req0 = 1; a0 = 8'h5A; b0 = 8'h33; cin0 = 0;
    serve8(0, w);
    req1 = 1; a1 = 8'hFF; b1 = 8'h01; cin1 = 1;
    serve8(0, w);

    // req1 raised mid-run of requester 0
    req0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
    serve8(3, w);
    serve8(0, w); chk("held_wait", w, 2);

    // reset in the middle of a run, with req0 present during the reset edge
    req1 = 1; a1 = 8'hFF; b1 = 8'hFF; cin1 = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt1 && t < 40);
    chk("abort_gnt1", gnt1, 1);
    req1 = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    req0 = 1; a0 = 8'h10; b0 = 8'h20; cin0 = 0;
    @(negedge clk);
    chk_reset8();
    last = 1;
    rst_n = 1;
    serve8(0, w); chk("post_rst_wait", w, 1);

    for (int k = 0; k < 16; k++) begin
      held = req0 || req1;
      if (!req0 && $urandom_range(1, 0) == 1) begin
        req0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
        req1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      end
      if (!req0 && !req1) begin
        req0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
      end
      serve8(0, w);
      if (held) chk("rand_held_wait", w, 2);
    end
    while (req0 || req1) serve8(0, w);

    // WIDTH=1 full-adder truth table, alternating requesters
    for (int c = 0; c < 8; c++) begin
      cv = 3'(c);
      tot = int'(cv[2]) + int'(cv[1]) + int'(cv[0]);
      if (cv[0]) begin
        rq1_w1 = 1; x1_w1 = cv[2]; y1_w1 = cv[1]; c1_w1 = cv[0];
      end else begin
        rq0_w1 = 1; x0_w1 = cv[2]; y0_w1 = cv[1]; c0_w1 = cv[0];
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!(gnt0_w1 || gnt1_w1) && t < 40);
      chk("w1_gnt0", gnt0_w1, !cv[0]);
      chk("w1_gnt1", gnt1_w1, cv[0]);
      chk("w1_done_early", done_w1, 0);
      rq0_w1 = 0; rq1_w1 = 0;
      x0_w1 = ~x0_w1; x1_w1 = ~x1_w1;
      @(negedge clk);
      chk("w1_done", done_w1, 1);
      chk("w1_sum", sum_w1, tot % 2);
      chk("w1_carry", carry_w1, tot / 2);
      chk("w1_owner", owner_w1, cv[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
